// File: rtl/pwm_update_ctrl.sv
// Shadow/active configuration controller for the PWM up/down counter.
// Commits are applied at once with a counter restart, or on the next counter wrap.
module pwm_update_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_ready,
  input  logic [15:0] count_val,
  output logic [15:0] cnt_period,
  output logic [7:0]  cnt_prescale,
  output logic        cnt_upnotdown,
  output logic        cnt_en,
  output logic        cnt_count_reset,
  output logic        commit_pending,
  output logic        commit_done
);

  typedef enum logic [1:0] {IDLE, WAIT_WRAP, APPLY} state_t;

  state_t      state;
  logic [15:0] sh_period;
  logic [2:0]  sh_prescale;
  logic        sh_en;
  logic        sh_upnotdown;
  logic        sh_immediate;
  logic [2:0]  act_prescale;
  logic [15:0] prev_count;
  logic        wrap;
  logic        cfg_acc;

  assign cfg_acc      = cfg_wr && cfg_ready;
  assign cnt_prescale = {5'b0, act_prescale};

  // Wrap is judged against the active (old) direction and period.
  assign wrap = (count_val != prev_count) &&
                (count_val == (cnt_upnotdown ? 16'h0000 : cnt_period));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      sh_period       <= 16'h00FF;
      sh_prescale     <= 3'd0;
      sh_en           <= 1'b0;
      sh_upnotdown    <= 1'b1;
      sh_immediate    <= 1'b0;
      cnt_period      <= 16'h00FF;
      act_prescale    <= 3'd0;
      cnt_upnotdown   <= 1'b1;
      cnt_en          <= 1'b0;
      cnt_count_reset <= 1'b0;
      commit_done     <= 1'b0;
      commit_pending  <= 1'b0;
      cfg_ready       <= 1'b1;
      prev_count      <= 16'h0000;
    end else begin
      prev_count      <= count_val;
      cnt_count_reset <= 1'b0;
      commit_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_acc) begin
            case (cfg_addr)
              2'd0: sh_period <= cfg_wdata;
              2'd1: sh_prescale <= (cfg_wdata[7:0] > 8'd7) ? 3'd7 : cfg_wdata[2:0];
              2'd2: begin
                sh_en        <= cfg_wdata[0];
                sh_upnotdown <= cfg_wdata[1];
                sh_immediate <= cfg_wdata[2];
              end
              2'd3: begin
                // A stopped or zero-period counter never wraps, so apply directly.
                if (sh_immediate || !cnt_en || (cnt_period == 16'h0000))
                  state <= APPLY;
                else
                  state <= WAIT_WRAP;
                cfg_ready      <= 1'b0;
                commit_pending <= 1'b1;
              end
            endcase
          end
        end
        WAIT_WRAP: begin
          if (wrap) begin
            cnt_period     <= sh_period;
            act_prescale   <= sh_prescale;
            cnt_upnotdown  <= sh_upnotdown;
            cnt_en         <= sh_en;
            commit_done    <= 1'b1;
            commit_pending <= 1'b0;
            cfg_ready      <= 1'b1;
            state          <= IDLE;
          end
        end
        APPLY: begin
          cnt_period      <= sh_period;
          act_prescale    <= sh_prescale;
          cnt_upnotdown   <= sh_upnotdown;
          cnt_en          <= sh_en;
          cnt_count_reset <= 1'b1;
          commit_done     <= 1'b1;
          commit_pending  <= 1'b0;
          cfg_ready       <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Scoreboard bench for pwm_update_ctrl: commits push expected active config,
// commit_done pops and compares it.
module tb_pwm_update_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic        cfg_ready;
  logic [15:0] count_val = 16'd0;
  logic [15:0] cnt_period;
  logic [7:0]  cnt_prescale;
  logic        cnt_upnotdown, cnt_en, cnt_count_reset, commit_pending, commit_done;

  pwm_update_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .count_val(count_val), .cnt_period(cnt_period),
    .cnt_prescale(cnt_prescale), .cnt_upnotdown(cnt_upnotdown), .cnt_en(cnt_en),
    .cnt_count_reset(cnt_count_reset), .commit_pending(commit_pending),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] per;
    logic [7:0]  pre;
    logic        en;
    logic        up;
    logic        rst_path;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model: shadow and active config
  logic [15:0] m_per, a_per;
  logic [7:0]  m_pre;
  logic        m_en, m_up, m_imm, a_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_per = 16'h00FF; m_pre = 8'd0; m_en = 1'b0; m_up = 1'b1; m_imm = 1'b0;
    a_per = 16'h00FF; a_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1 cfg_wr = 1'b0;
    case (a)
      2'd0: m_per = d;
      2'd1: m_pre = (d[7:0] > 8'd7) ? 8'd7 : d[7:0];
      2'd2: begin m_en = d[0]; m_up = d[1]; m_imm = d[2]; end
      default: ;
    endcase
  endtask

  task automatic wr_drop(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    chk("ready_low_drop", cfg_ready, 0);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1 cfg_wr = 1'b0;
  endtask

  task automatic commit();
    exp_t e;
    @(negedge clk);
    cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 16'hFFFF;
    e.per = m_per; e.pre = m_pre; e.en = m_en; e.up = m_up;
    e.rst_path = m_imm || !a_en || (a_per == 16'd0);
    sb.push_back(e);
    a_per = m_per; a_en = m_en;
    @(posedge clk); #1 cfg_wr = 1'b0;
  endtask

  task automatic cyc(input logic [15:0] v);
    @(negedge clk);
    count_val = v;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_period"}, cnt_period, 16'h00FF);
    chk({tag, "_prescale"}, cnt_prescale, 0);
    chk({tag, "_up"}, cnt_upnotdown, 1);
    chk({tag, "_en"}, cnt_en, 0);
    chk({tag, "_cr"}, cnt_count_reset, 0);
    chk({tag, "_done"}, commit_done, 0);
    chk({tag, "_pending"}, commit_pending, 0);
    chk({tag, "_ready"}, cfg_ready, 1);
  endtask

  // Scoreboard consumer and pulse-shape monitor
  logic prev_done = 1'b0, prev_cr = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && commit_done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_period", cnt_period, e.per);
        chk("sb_prescale", cnt_prescale, e.pre);
        chk("sb_en", cnt_en, e.en);
        chk("sb_up", cnt_upnotdown, e.up);
        chk("sb_count_reset", cnt_count_reset, e.rst_path);
      end
    end
    if (cnt_count_reset && !commit_done) chk("cr_without_done", 1, 0);
    if (commit_done && prev_done) chk("done_width", 2, 1);
    if (cnt_count_reset && prev_cr) chk("cr_width", 2, 1);
    prev_done <= commit_done;
    prev_cr   <= cnt_count_reset;
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    // Immediate commit with full timing
    wr(2'd0, 16'd100);
    @(negedge clk); chk("shadow_no_active", cnt_period, 16'h00FF);
    wr(2'd1, 16'd2);
    wr(2'd2, 16'h0007);
    commit();
    @(negedge clk);
    chk("imm_n1_ready", cfg_ready, 0);
    chk("imm_n1_pending", commit_pending, 1);
    chk("imm_n1_period", cnt_period, 16'h00FF);
    @(negedge clk);
    chk("imm_n2_ready", cfg_ready, 1);
    chk("imm_n2_pending", commit_pending, 0);
    chk("imm_n2_cr", cnt_count_reset, 1);
    @(negedge clk);
    chk("imm_n3_cr", cnt_count_reset, 0);
    chk("imm_n3_done", commit_done, 0);

    // Synchronised commit, counting up: period 10 -> 20
    wr(2'd0, 16'd10);
    commit();
    repeat (2) @(negedge clk);
    wr(2'd2, 16'h0003);
    wr(2'd0, 16'd20);
    commit();
    cyc(0); chk("up_wait_pending", commit_pending, 1);
    cyc(0); chk("up_hold_no_wrap", cnt_period, 16'd10);
    wr_drop(2'd0, 16'd555);
    cyc(9);
    cyc(10); chk("up_pre_wrap_pending", commit_pending, 1);
    cyc(0);  chk("up_wrap_cycle_old", cnt_period, 16'd10);
    cyc(1);
    chk("up_post_period", cnt_period, 16'd20);
    chk("up_post_pending", commit_pending, 0);
    chk("up_post_ready", cfg_ready, 1);

    // Synchronised commit, counting down with period 8
    wr(2'd0, 16'd8);
    wr(2'd2, 16'h0005);
    commit();
    repeat (2) @(negedge clk);
    wr(2'd1, 16'd1);
    wr(2'd2, 16'h0001);
    commit();
    cyc(3); cyc(2); cyc(1);
    cyc(0); chk("dn_zero_no_wrap", commit_pending, 1);
    cyc(8); chk("dn_wrap_cycle_old", cnt_prescale, 2);
    cyc(7);
    chk("dn_post_prescale", cnt_prescale, 1);
    chk("dn_post_pending", commit_pending, 0);

    // Stopped counter takes the apply path
    wr(2'd2, 16'h0004);
    commit();
    repeat (2) @(negedge clk);
    wr(2'd0, 16'd50);
    wr(2'd2, 16'h0002);
    commit();
    @(negedge clk); chk("stop_n1_done", commit_done, 0);
    @(negedge clk); chk("stop_n2_done", commit_done, 1);

    // Zero period takes the apply path; prescale saturation
    wr(2'd0, 16'd0);
    wr(2'd2, 16'h0007);
    commit();
    repeat (2) @(negedge clk);
    wr(2'd0, 16'd30);
    wr(2'd1, 16'd200);
    wr(2'd2, 16'h0003);
    commit();
    @(negedge clk); chk("zero_n1_done", commit_done, 0);
    @(negedge clk); chk("zero_n2_done", commit_done, 1);
    chk("sat_prescale", cnt_prescale, 7);

    // Asynchronous reset while waiting for a wrap
    cyc(5);
    wr(2'd0, 16'd40);
    commit();
    @(negedge clk); chk("rstw_pending", commit_pending, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(0);
    cyc(1);
    chk("rst_no_done", commit_done, 0);
    wr(2'd0, 16'd60);
    wr(2'd2, 16'h0001);
    commit();
    repeat (3) @(negedge clk);
    chk("post_rst_period", cnt_period, 16'd60);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
